// File: rtl/param_serializer.sv
// Frame serializer: captures NUM_WORDS x WORD_WIDTH words on a valid/ready handshake and shifts them out one bit per clock.
// Optional macro SER_PARITY_EN appends an even-parity cycle after every word.
module param_serializer #(
    parameter int NUM_WORDS  = 8,
    parameter int WORD_WIDTH = 32,
    localparam int CW = $clog2(WORD_WIDTH),
    localparam int WC = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
    input  logic                            CLK,
    input  logic                            RESET,
    input  logic                            LOAD_VALID,
    output logic                            LOAD_READY,
    input  logic [NUM_WORDS*WORD_WIDTH-1:0] PAR_IN,
    input  logic                            MSB_FIRST,
    output logic                            SERIAL_OUT,
    output logic                            SERIAL_VALID,
    output logic                            WORD_DONE,
    output logic                            COMPLETE,
    output logic [CW-1:0]                   BIT_COUNT,
    output logic [WC-1:0]                   WORD_COUNT
);

    localparam logic [CW-1:0] BIT_LAST  = CW'(WORD_WIDTH - 1);
    localparam logic [WC-1:0] WORD_LAST = WC'(NUM_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT
`ifdef SER_PARITY_EN
        , PARITY
`endif
    } state_t;

    state_t                state_q, state_d;
    logic [WORD_WIDTH-1:0] frame_q [NUM_WORDS];
    logic                  msb_q, msb_d;
    logic [CW-1:0]         bit_q, bit_d;
    logic [WC-1:0]         word_q, word_d;
    logic                  out_q, out_d;
    logic                  vld_q, vld_d;
    logic                  wdone_q, wdone_d;
    logic                  cmpl_q, cmpl_d;
    logic                  load, adv_word, frame_end;
    logic [WORD_WIDTH-1:0] src_word;

    function automatic logic pick_bit(input logic [WORD_WIDTH-1:0] w, input logic msb,
                                      input logic [CW-1:0] idx);
        return msb ? w[BIT_LAST - idx] : w[idx];
    endfunction

    // The final bit of a frame is the only busy cycle that can accept the next frame.
    assign LOAD_READY   = (state_q == IDLE) || cmpl_q;
    assign SERIAL_OUT   = out_q;
    assign SERIAL_VALID = vld_q;
    assign WORD_DONE    = wdone_q;
    assign COMPLETE     = cmpl_q;
    assign BIT_COUNT    = bit_q;
    assign WORD_COUNT   = word_q;

    always_comb begin
        state_d   = state_q;
        msb_d     = msb_q;
        bit_d     = bit_q;
        word_d    = word_q;
        out_d     = 1'b0;
        vld_d     = 1'b0;
        wdone_d   = 1'b0;
        cmpl_d    = 1'b0;
        load      = 1'b0;
        adv_word  = 1'b0;
        frame_end = 1'b0;

        case (state_q)
            IDLE: frame_end = 1'b1;
            SHIFT: begin
                if (bit_q != BIT_LAST) bit_d = bit_q + CW'(1);
`ifdef SER_PARITY_EN
                else state_d = PARITY;
`else
                else if (word_q == WORD_LAST) frame_end = 1'b1;
                else adv_word = 1'b1;
`endif
            end
`ifdef SER_PARITY_EN
            PARITY: begin
                if (word_q == WORD_LAST) frame_end = 1'b1;
                else adv_word = 1'b1;
            end
`endif
            default: state_d = IDLE;
        endcase

        if (adv_word) begin
            state_d = SHIFT;
            word_d  = word_q + WC'(1);
            bit_d   = '0;
        end
        if (frame_end) begin
            word_d = '0;
            bit_d  = '0;
            if (LOAD_VALID) begin
                load    = 1'b1;
                msb_d   = MSB_FIRST;
                state_d = SHIFT;
            end else begin
                state_d = IDLE;
            end
        end

        // On a load the shadow register is not yet written, so bit 0 comes straight from PAR_IN.
        src_word = load ? PAR_IN[WORD_WIDTH-1:0] : frame_q[word_d];
        if (state_d == SHIFT) begin
            vld_d = 1'b1;
            out_d = pick_bit(src_word, msb_d, bit_d);
`ifndef SER_PARITY_EN
            wdone_d = (bit_d == BIT_LAST);
            cmpl_d  = wdone_d && (word_d == WORD_LAST);
`endif
        end
`ifdef SER_PARITY_EN
        else if (state_d == PARITY) begin
            vld_d   = 1'b1;
            out_d   = ^frame_q[word_d];
            wdone_d = 1'b1;
            cmpl_d  = (word_d == WORD_LAST);
        end
`endif
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= IDLE;
            msb_q   <= 1'b0;
            bit_q   <= '0;
            word_q  <= '0;
            out_q   <= 1'b0;
            vld_q   <= 1'b0;
            wdone_q <= 1'b0;
            cmpl_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            msb_q   <= msb_d;
            bit_q   <= bit_d;
            word_q  <= word_d;
            out_q   <= out_d;
            vld_q   <= vld_d;
            wdone_q <= wdone_d;
            cmpl_q  <= cmpl_d;
        end
    end

    // Shadow data needs no reset: it is only read after a fresh capture.
    always_ff @(posedge CLK) begin
        if (load) begin
            for (int i = 0; i < NUM_WORDS; i++) begin
                frame_q[i] <= PAR_IN[i*WORD_WIDTH +: WORD_WIDTH];
            end
        end
    end

endmodule

// File: tb/tb_param_serializer.sv
// Directed bench for param_serializer (N=8, W=32): vector table over recorded frames plus reset/back-to-back sequences.
// Expectations follow SER_PARITY_EN when the macro is defined.
module tb_param_serializer;

    localparam int N = 8;
    localparam int W = 32;
`ifdef SER_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int WL = W + PB;
    localparam int FL = N * WL;

    logic             CLK, RESET, LOAD_VALID, LOAD_READY, MSB_FIRST;
    logic [N*W-1:0]   PAR_IN;
    logic             SERIAL_OUT, SERIAL_VALID, WORD_DONE, COMPLETE;
    logic [4:0]       BIT_COUNT;
    logic [2:0]       WORD_COUNT;

    param_serializer #(.NUM_WORDS(N), .WORD_WIDTH(W)) dut (
        .CLK(CLK), .RESET(RESET), .LOAD_VALID(LOAD_VALID), .LOAD_READY(LOAD_READY),
        .PAR_IN(PAR_IN), .MSB_FIRST(MSB_FIRST), .SERIAL_OUT(SERIAL_OUT),
        .SERIAL_VALID(SERIAL_VALID), .WORD_DONE(WORD_DONE), .COMPLETE(COMPLETE),
        .BIT_COUNT(BIT_COUNT), .WORD_COUNT(WORD_COUNT)
    );

    always #5 CLK = ~CLK;

    int n_total = 0;
    int n_pass  = 0;

    logic r_out [0:5][0:599];
    logic r_vld [0:5][0:599];
    logic r_wd  [0:5][0:599];
    logic r_cm  [0:5][0:599];
    logic r_rdy [0:5][0:599];
    int   r_bc  [0:5][0:599];
    int   r_wc  [0:5][0:599];

    typedef struct {
        int   f;
        int   c;
        logic out, vld, wd, cm, rdy;
        int   bc, wc;
    } vec_t;
    vec_t vecs[$];

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic logic exp_bit(input logic [N*W-1:0] par, input logic msb, input int c);
        int idx = c - 1;
        int w = idx / WL;
        int b = idx % WL;
        logic [W-1:0] wd = par[w*W +: W];
        if (b == W) return ^wd;
        return msb ? wd[W-1-b] : wd[b];
    endfunction

    function automatic int count_hi(input int f, input int lo, input int hi, input int sel);
        int n = 0;
        for (int c = lo; c <= hi; c++) begin
            case (sel)
                0: n += int'(r_wd[f][c]);
                1: n += int'(r_cm[f][c]);
                default: n += int'(r_vld[f][c]);
            endcase
        end
        return n;
    endfunction

    task automatic start(input logic [N*W-1:0] par, input logic msb, input logic hold,
                         input logic [N*W-1:0] par2, input logic msb2);
        int k = 0;
        @(negedge CLK);
        PAR_IN = par; MSB_FIRST = msb; LOAD_VALID = 1'b1;
        while (!LOAD_READY && k < 1000) begin
            @(negedge CLK);
            k++;
        end
        check("handshake_ready", int'(LOAD_READY), 1);
        @(posedge CLK);
        #1;
        if (hold) begin
            PAR_IN = par2; MSB_FIRST = msb2;
        end else begin
            LOAD_VALID = 1'b0; PAR_IN = '1; MSB_FIRST = ~msb;
        end
    endtask

    task automatic capture(input int f, input int n, input int raise_at, input int drop_at);
        for (int c = 1; c <= n; c++) begin
            @(negedge CLK);
            r_out[f][c] = SERIAL_OUT;  r_vld[f][c] = SERIAL_VALID;
            r_wd[f][c]  = WORD_DONE;   r_cm[f][c]  = COMPLETE;
            r_rdy[f][c] = LOAD_READY;
            r_bc[f][c]  = int'(BIT_COUNT); r_wc[f][c] = int'(WORD_COUNT);
            if (c == raise_at) LOAD_VALID = 1'b1;
            if (c == drop_at)  LOAD_VALID = 1'b0;
        end
    endtask

    task automatic check_stream(input string nm, input int f, input int off,
                                input logic [N*W-1:0] par, input logic msb);
        int bad = 0;
        for (int c = 1; c <= FL; c++) begin
            if (r_vld[f][off+c] !== 1'b1 || r_out[f][off+c] !== exp_bit(par, msb, c)) bad++;
        end
        check(nm, bad, 0);
    endtask

    task automatic check_reset_outputs(input string nm);
        check({nm, "_serial_out"}, int'(SERIAL_OUT), 0);
        check({nm, "_serial_valid"}, int'(SERIAL_VALID), 0);
        check({nm, "_word_done"}, int'(WORD_DONE), 0);
        check({nm, "_complete"}, int'(COMPLETE), 0);
        check({nm, "_bit_count"}, int'(BIT_COUNT), 0);
        check({nm, "_word_count"}, int'(WORD_COUNT), 0);
        check({nm, "_load_ready"}, int'(LOAD_READY), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N*W-1:0] p, q;
        int nv;

        // f, cycle, out, vld, wd, cm, rdy, bit_count, word_count
        vecs.push_back('{0, 1,      1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0});
        vecs.push_back('{0, 2,      1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1, 0});
        vecs.push_back('{0, WL,     1'(PB), 1'b1, 1'b1, 1'b0, 1'b0, W-1, 0});
        vecs.push_back('{0, WL+1,   1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1});
        vecs.push_back('{0, FL-1,   1'b0, 1'b1, 1'b0, 1'b0, 1'b0, W-2+PB, N-1});
        vecs.push_back('{0, FL,     1'b0, 1'b1, 1'b1, 1'b1, 1'b1, W-1, N-1});
        vecs.push_back('{0, FL+1,   1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0});
        vecs.push_back('{1, 1,      1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0});
        vecs.push_back('{1, 2,      1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1, 0});
        vecs.push_back('{1, W,      1'b0, 1'b1, 1'(1-PB), 1'b0, 1'b0, W-1, 0});
        vecs.push_back('{1, WL+1,   1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1});
        vecs.push_back('{1, WL+W,   1'b1, 1'b1, 1'(1-PB), 1'b0, 1'b0, W-1, 1});
        vecs.push_back('{1, 2*WL+1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 2});
        vecs.push_back('{1, FL+1,   1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0});
        vecs.push_back('{2, 1,      1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0});
        vecs.push_back('{2, FL,     1'b0, 1'b1, 1'b1, 1'b1, 1'b1, W-1, N-1});
        vecs.push_back('{2, FL+1,   1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0});
        vecs.push_back('{2, 2*FL,   1'b0, 1'b1, 1'b1, 1'b1, 1'b1, W-1, N-1});
        vecs.push_back('{2, 2*FL+1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0});
        vecs.push_back('{4, 1,      1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0});
        vecs.push_back('{4, 2,      1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1, 0});
        vecs.push_back('{4, FL,     1'b0, 1'b1, 1'b1, 1'b1, 1'b1, W-1, N-1});
        vecs.push_back('{5, 3,      1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2, 0});
        vecs.push_back('{5, 4,      1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3, 0});
        vecs.push_back('{5, W+1,    1'(PB), 1'b1, 1'(PB), 1'b0, 1'b0, PB*(W-1), 1-PB});
        vecs.push_back('{5, FL,     1'b0, 1'b1, 1'b1, 1'b1, 1'b1, W-1, N-1});

        CLK = 1'b0; RESET = 1'b1; LOAD_VALID = 1'b0; PAR_IN = '0; MSB_FIRST = 1'b0;
        #2;
        check_reset_outputs("power_on_reset");
        @(negedge CLK);
        @(negedge CLK);
        RESET = 1'b0;

        // LSB-first single set bit; PAR_IN is scrambled after the handshake.
        p = '0; p[31:0] = 32'h0000_0001;
        start(p, 1'b0, 1'b0, '0, 1'b0);
        capture(0, FL+2, 0, 0);
        check_stream("f0_stream", 0, 0, p, 1'b0);
        check("f0_word_done_count", count_hi(0, 1, FL, 0), N);
        check("f0_complete_count", count_hi(0, 1, FL, 1), 1);

        // MSB-first; a LOAD_VALID pulse mid-frame must be ignored.
        p = '0; p[31:0] = 32'h8000_0000; p[63:32] = 32'hFFFF_FFFF;
        start(p, 1'b1, 1'b0, '0, 1'b0);
        capture(1, FL+2, 50, 51);
        check_stream("f1_stream", 1, 0, p, 1'b1);
        check("f1_word_done_count", count_hi(1, 1, FL, 0), N);
        check("f1_complete_count", count_hi(1, 1, FL, 1), 1);

        // Back-to-back frames with LOAD_VALID held high; second frame changes data and bit order.
        p = '0; p[31:0] = 32'h0000_0003;
        q = '0; q[31:0] = 32'h8000_0000; q[127:96] = 32'h1234_5678;
        start(p, 1'b0, 1'b1, q, 1'b1);
        capture(2, 2*FL+2, 0, FL+10);
        check("b2b_valid_cycles", count_hi(2, 1, 2*FL, 2), 2*FL);
        check("b2b_complete_count", count_hi(2, 1, 2*FL, 1), 2);
        check_stream("b2b_frame1_stream", 2, 0, p, 1'b0);
        check_stream("b2b_frame2_stream", 2, FL, q, 1'b1);

        // Abort at cycle 100 with an asynchronous reset between clock edges.
        p = '0; p[31:0] = 32'hFFFF_FFFF; p[63:32] = 32'hDEAD_BEEF;
        start(p, 1'b0, 1'b0, '0, 1'b0);
        capture(3, 100, 0, 0);
        check("abort_word_done_before", count_hi(3, 1, 100, 0), 3);
        check("abort_complete_before", count_hi(3, 1, 100, 1), 0);
        #2 RESET = 1'b1;
        #1;
        check_reset_outputs("async_reset");
        @(posedge CLK);
        #1;
        @(negedge CLK);
        RESET = 1'b0;
        nv = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            nv += int'(SERIAL_VALID) + int'(COMPLETE) + int'(WORD_DONE);
        end
        check("abort_quiet_after_reset", nv, 0);

        p = '0; p[31:0] = 32'h0000_0002;
        start(p, 1'b0, 1'b0, '0, 1'b0);
        capture(4, FL+2, 0, 0);
        check_stream("f4_stream", 4, 0, p, 1'b0);
        check("f4_complete_count", count_hi(4, 1, FL, 1), 1);

        p = '0; p[31:0] = 32'h0000_0007;
        start(p, 1'b0, 1'b0, '0, 1'b0);
        capture(5, FL+2, 0, 0);
        check_stream("f5_stream", 5, 0, p, 1'b0);
        check("f5_word_done_count", count_hi(5, 1, FL, 0), N);

        foreach (vecs[i]) begin
            vec_t v = vecs[i];
            string t = $sformatf("vec%0d_f%0d_c%0d", i, v.f, v.c);
            check({t, "_serial_out"},   int'(r_out[v.f][v.c]), int'(v.out));
            check({t, "_serial_valid"}, int'(r_vld[v.f][v.c]), int'(v.vld));
            check({t, "_word_done"},    int'(r_wd[v.f][v.c]),  int'(v.wd));
            check({t, "_complete"},     int'(r_cm[v.f][v.c]),  int'(v.cm));
            check({t, "_load_ready"},   int'(r_rdy[v.f][v.c]), int'(v.rdy));
            check({t, "_bit_count"},    r_bc[v.f][v.c],        v.bc);
            check({t, "_word_count"},   r_wc[v.f][v.c],        v.wc);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
